mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit, the consumer of the EX/MEM pipeline register. It turns the registered `mem_op`/`mem_addr`/`mem_data` fields into a req/gnt/rvalid data-memory transaction, aligns and extends load data, and stalls the pipeline until the access completes. It also contains the MEM/WB register for GPR and CSR write-back fields.

## Interface
- `TIMEOUT_CYCLES`, default 64: bus watchdog limit in cycles, 2..255. Used only when `LSU_BUS_TIMEOUT_EN` is defined.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `reg_waddr_i`/`reg_we_i`/`reg_wdata_i` in 5/1/32: GPR write-back fields from EX/MEM.
- `mem_addr_i`/`mem_data_i`/`mem_we_i`/`mem_op_i` in 32/32/1/4: memory request fields from EX/MEM.
- `csr_we_i`/`csr_waddr_i`/`csr_wdata_i` in 1/12/32: CSR write fields from EX/MEM.
- `reg_waddr_o`/`reg_we_o`/`reg_wdata_o` out 5/1/32: registered GPR write-back.
- `csr_we_o`/`csr_waddr_o`/`csr_wdata_o` out 1/12/32: registered CSR write-back.
- `stall_req_o` out 1: combinational; requests that the pipeline hold upstream stages.
- `misaligned_o`/`fault_addr_o` out 1/32: registered one-cycle pulse on a misaligned access, plus the faulting address.
- `bus_err_o` out 1: registered one-cycle pulse on a watchdog expiry.
- `dmem_req_o`/`dmem_we_o`/`dmem_addr_o`/`dmem_be_o`/`dmem_wdata_o` out 1/1/32/4/32: data-memory request. Address is word-aligned (`[1:0]`=0).
- `dmem_gnt_i`/`dmem_rvalid_i`/`dmem_rdata_i` in 1/1/32: grant, response valid, read data.

## Operation
- `mem_op` encoding: NOP=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8. Values 9–15 are treated as NOP.
- Stores are ops 6–8. `dmem_we_o` is derived from the op; `mem_we_i` must agree with it.
- Misalignment:
  - LH/LHU/SH: `addr[0]`≠0.
  - LW/SW: `addr[1:0]`≠0.
  - Response: no request is issued and there is no stall. Next edge: `misaligned_o`=1, `fault_addr_o`=`mem_addr_i`, `reg_we_o`=0, `csr_we_o`=0.
- Byte enables:
  - SB/LB/LBU: `4'b0001<<addr[1:0]`.
  - SH/LH/LHU: `4'b0011<<{addr[1],1'b0}`.
  - Word: `4'b1111`.
- Store data:
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: as-is.
- Load data: the lane selected by `addr[1:0]`. LB/LH are sign-extended, LBU/LHU are zero-extended, LW is unchanged.
- FSM states:
  - IDLE: on a valid aligned memory op, drive `dmem_req_o`=1. If `dmem_gnt_i`=1, go to RSP; otherwise go to REQ.
  - REQ: hold `dmem_req_o` and all request fields stable until `dmem_gnt_i`=1, then go to RSP.
  - RSP: `dmem_req_o`=0. On `dmem_rvalid_i`=1, go to IDLE.
- `stall_req_o`=1 whenever a valid aligned memory op is present, except in the RSP cycle where `dmem_rvalid_i`=1. Upstream holds its inputs stable while `stall_req_o`=1.
- MEM/WB register, by cycle type:
  - Stalled cycle: `reg_we_o`=0 and `csr_we_o`=0 (bubble).
  - Non-memory op: capture inputs unchanged.
  - Completing load: `reg_wdata_o`=extended data, `reg_we_o`=`reg_we_i`, CSR fields captured.
  - Completing store: capture inputs unchanged.
- `dmem_gnt_i` in RSP and `dmem_rvalid_i` in IDLE/REQ are ignored.
- Reset (`rst_n_i`=0 at an edge):
  - State returns to IDLE and any in-flight access is abandoned.
  - All registered outputs go to 0.
  - `dmem_req_o`=0 and `stall_req_o`=0 while reset is asserted.
  - A late `dmem_rvalid_i` arriving after reset is ignored.

## Timing
- Zero-wait memory (gnt in the request cycle, rvalid on the next): one stall cycle. Write-back is valid 2 edges after the op appears.
- Each extra gnt-wait or rvalid-wait cycle adds one stall cycle.
- Non-memory op and misaligned op: write-back or fault pulse appears one edge later, with no stall.
- Back-to-back memory ops: the next request can be issued in the IDLE cycle right after completion.
- `stall_req_o` and the `dmem_*` request outputs are combinational from the state and inputs. All write-back, fault and error outputs are registered.

## Configuration
- `LSU_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ or RSP and increments each cycle spent there.
  - Expiry: `TIMEOUT_CYCLES` cycles in one state without gnt (REQ) or rvalid (RSP).
  - On expiry: go to IDLE; that cycle `stall_req_o`=0; next edge `bus_err_o`=1, `reg_we_o`=0.
- `LSU_BUS_TIMEOUT_EN` undefined: no counter and no expiry; waits indefinitely; `bus_err_o` is tied to 0.

## Test plan
- LB at 0x1003, memory returns 0x80FF_FF12 with zero-wait → `dmem_addr_o`=0x1000, `dmem_be_o`=1000b, one stall cycle, `reg_wdata_o`=0xFFFF_FF80.
- SH at 0x2002, data 0x1234_ABCD, gnt delayed 3 cycles → `dmem_be_o`=1100b, `dmem_wdata_o`=0xABCD_ABCD, request fields stable through the wait, 4 stall cycles, `reg_we_o`=0.
- LW at 0x3001 → no `dmem_req_o`, no stall, `misaligned_o` pulse, `fault_addr_o`=0x3001.
- Non-memory op with `csr_we_i`=1, addr 0x300, data 0x8 → next edge `csr_we_o`=1, `csr_waddr_o`=0x300, `csr_wdata_o`=0x8.
- Reset asserted in RSP, then rvalid arrives → IDLE, all outputs 0, rvalid ignored, no write-back.
- With `LSU_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, gnt never asserted → after 4 REQ cycles `bus_err_o` pulses and the stall drops.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Purpose: data-memory req/gnt/rvalid bus between the load/store unit and data memory.
// Latency: none, wires only.
// Backpressure: master holds req and all request fields stable until gnt.
// Ports: master drives dmem_req_o/we_o/addr_o/be_o/wdata_o; slave drives dmem_gnt_i/rvalid_i/rdata_i.
interface mem_access_unit_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: memory-stage load/store unit plus MEM/WB register (GPR and CSR write-back).
// Latency: write-back 1 edge for non-memory/misaligned ops, 2 edges for a zero-wait access.
// Backpressure: stall_req_o holds upstream until rvalid; gnt/rvalid waits each add one stall cycle.
// Ports: EX/MEM fields in (reg_*, mem_*, csr_*), registered write-back/fault/error out,
//        combinational stall_req_o, data-memory bus via the dmem interface (master).
// Optional: define LSU_BUS_TIMEOUT_EN for a TIMEOUT_CYCLES bus watchdog driving bus_err_o.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_op_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [4:0]  reg_waddr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_req_o,
  output logic        misaligned_o,
  output logic [31:0] fault_addr_o,
  output logic        bus_err_o,
  mem_access_unit_if.master dmem
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_e;
  state_e state_q, state_d;

  logic        is_load, is_store, is_mem, misaligned, mem_valid;
  logic        rsp_done, timeout_hit;
  logic [3:0]  be;
  logic [31:0] wdata, lane, load_data;

  logic [4:0]  reg_waddr_q;
  logic        reg_we_q, csr_we_q, misaligned_q;
  logic [31:0] reg_wdata_q, csr_wdata_q, fault_addr_q;
  logic [11:0] csr_waddr_q;

  // Direction comes from the op; mem_we_i is redundant with it.
  logic unused_we;
  assign unused_we = mem_we_i;

  always_comb begin
    is_load    = mem_op_i inside {[OP_LB:OP_LHU]};
    is_store   = mem_op_i inside {[OP_SB:OP_SW]};
    is_mem     = is_load || is_store;
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = mem_data_i;
    unique case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        be    = 4'b0001 << mem_addr_i[1:0];
        wdata = {4{mem_data_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        misaligned = mem_addr_i[0];
        be         = 4'b0011 << {mem_addr_i[1], 1'b0};
        wdata      = {2{mem_data_i[15:0]}};
      end
      OP_LW, OP_SW: begin
        misaligned = |mem_addr_i[1:0];
        be         = 4'b1111;
      end
      default: ;
    endcase
    mem_valid = is_mem && !misaligned;

    // Shift the addressed lane down to bit 0; aligned halfwords/words land correctly too.
    lane = dmem.dmem_rdata_i >> {mem_addr_i[1:0], 3'b000};
    unique case (mem_op_i)
      OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_data = {24'd0, lane[7:0]};
      OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  load_data = {16'd0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  assign rsp_done = (state_q == ST_RSP) && dmem.dmem_rvalid_i;

  assign dmem.dmem_req_o   = rst_n_i && (((state_q == ST_IDLE) && mem_valid) || (state_q == ST_REQ));
  assign dmem.dmem_we_o    = is_store;
  assign dmem.dmem_addr_o  = {mem_addr_i[31:2], 2'b00};
  assign dmem.dmem_be_o    = be;
  assign dmem.dmem_wdata_o = wdata;

  assign stall_req_o = rst_n_i && mem_valid && !rsp_done && !timeout_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mem_valid) state_d = dmem.dmem_gnt_i ? ST_RSP : ST_REQ;
      ST_REQ:  if (dmem.dmem_gnt_i) state_d = ST_RSP;
               else if (timeout_hit) state_d = ST_IDLE;
      ST_RSP:  if (dmem.dmem_rvalid_i || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      reg_waddr_q  <= '0;
      reg_we_q     <= 1'b0;
      reg_wdata_q  <= '0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      misaligned_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= 1'b0;
      if (misaligned) begin
        misaligned_q <= 1'b1;
        fault_addr_q <= mem_addr_i;
        reg_we_q     <= 1'b0;
        csr_we_q     <= 1'b0;
      end else if (stall_req_o || timeout_hit) begin
        // Bubble while waiting on memory or when the access was abandoned.
        reg_we_q <= 1'b0;
        csr_we_q <= 1'b0;
      end else begin
        reg_waddr_q <= reg_waddr_i;
        reg_we_q    <= reg_we_i;
        reg_wdata_q <= (is_load && rsp_done) ? load_data : reg_wdata_i;
        csr_we_q    <= csr_we_i;
        csr_waddr_q <= csr_waddr_i;
        csr_wdata_q <= csr_wdata_i;
      end
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       bus_err_q;

  // The counter holds the number of cycles already spent in the current wait state.
  assign timeout_hit = (((state_q == ST_REQ) && !dmem.dmem_gnt_i) ||
                        ((state_q == ST_RSP) && !dmem.dmem_rvalid_i)) &&
                       (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (state_d != state_q)      wait_cnt_q <= '0;
      else if (state_q != ST_IDLE) wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign bus_err_o      = 1'b0;
`endif

  assign reg_waddr_o  = reg_waddr_q;
  assign reg_we_o     = reg_we_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign csr_we_o     = csr_we_q;
  assign csr_waddr_o  = csr_waddr_q;
  assign csr_wdata_o  = csr_wdata_q;
  assign misaligned_o = misaligned_q;
  assign fault_addr_o = fault_addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i, mem_addr_i, mem_data_i, csr_wdata_i;
  logic        mem_we_i, csr_we_i;
  logic [3:0]  mem_op_i;
  logic [11:0] csr_waddr_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o, csr_we_o, stall_req_o, misaligned_o, bus_err_o;
  logic [31:0] reg_wdata_o, csr_wdata_o, fault_addr_o;
  logic [11:0] csr_waddr_o;

  int total = 0;
  int bad = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  int          obs_stalls;

  always #5 clk = ~clk;

  mem_access_unit_if dmem_if();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i), .mem_op_i(mem_op_i),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_req_o(stall_req_o), .misaligned_o(misaligned_o), .fault_addr_o(fault_addr_o),
    .bus_err_o(bus_err_o), .dmem(dmem_if.master)
  );

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic int lane_off(input logic [3:0] op, input logic [31:0] a);
    int sz;
    sz = op_size(op);
    if (sz == 0) return 0;
    return (int'(a % 4) / sz) * sz;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    return 4'(((1 << op_size(op)) - 1) << lane_off(op, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op_size(op))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r);
    longint v;
    int     bits;
    bits = 8 * op_size(op);
    v = longint'(r >> (8 * lane_off(op, a))) & ((64'd1 << bits) - 1);
    if ((op == 4'd1 || op == 4'd2) && v >= longint'(64'd1 << (bits - 1))) v = v - longint'(64'd1 << bits);
    return v[31:0];
  endfunction

  // ---------------- scenario drivers ----------------
  task automatic idle_inputs();
    mem_op_i = 4'd0; mem_addr_i = '0; mem_data_i = '0; mem_we_i = 1'b0;
    reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    csr_we_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0;
    dmem_if.dmem_gnt_i = 1'b0; dmem_if.dmem_rvalid_i = 1'b0; dmem_if.dmem_rdata_i = '0;
  endtask

  // Presents one aligned memory op, answers with gw grant-wait and rw rvalid-wait cycles.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int gw, input int rw, input logic rwe);
    logic        store;
    logic [31:0] rwd, ewb;
    logic [4:0]  wa;
    int          st;
    store = (op >= 4'd6);
    rwd = $urandom; wa = 5'($urandom);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = wd; mem_we_i = store;
    reg_we_i = rwe; reg_waddr_i = wa; reg_wdata_i = rwd;
    csr_we_i = 1'b0; csr_waddr_i = 12'($urandom); csr_wdata_i = $urandom;
    dmem_if.dmem_rvalid_i = 1'b0;
    st = 0;
    for (int c = 0; c <= gw; c++) begin
      dmem_if.dmem_gnt_i = (c == gw);
      #1;
      total++;
      if ({dmem_if.dmem_req_o, dmem_if.dmem_we_o, dmem_if.dmem_addr_o, dmem_if.dmem_be_o} !==
          {1'b1, store, addr & 32'hFFFF_FFFC, m_be(op, addr)} ||
          (store && dmem_if.dmem_wdata_o !== m_wdata(op, wd)))
        $display("FAIL req_fields op=%0d cyc=%0d: got req=%b we=%b addr=%h be=%b wd=%h, want req=1 we=%b addr=%h be=%b wd=%h",
                 op, c, dmem_if.dmem_req_o, dmem_if.dmem_we_o, dmem_if.dmem_addr_o, dmem_if.dmem_be_o,
                 dmem_if.dmem_wdata_o, store, addr & 32'hFFFF_FFFC, m_be(op, addr), m_wdata(op, wd));
      if (dmem_if.dmem_req_o !== 1'b1 || dmem_if.dmem_addr_o !== (addr & 32'hFFFF_FFFC) ||
          dmem_if.dmem_be_o !== m_be(op, addr) || dmem_if.dmem_we_o !== store ||
          (store && dmem_if.dmem_wdata_o !== m_wdata(op, wd))) bad++;
      if (c == 0) begin
        obs_addr = dmem_if.dmem_addr_o; obs_be = dmem_if.dmem_be_o; obs_wdata = dmem_if.dmem_wdata_o;
      end else begin
        total++;
        if ({reg_we_o, csr_we_o, bus_err_o} !== 3'b000) begin
          bad++;
          $display("FAIL bubble_gnt: got we/csr/err=%b want 000", {reg_we_o, csr_we_o, bus_err_o});
        end
      end
      if (stall_req_o === 1'b1) st++;
      @(posedge clk); #1;
    end
    dmem_if.dmem_gnt_i = 1'b0;
    for (int c = 0; c <= rw; c++) begin
      dmem_if.dmem_rvalid_i = (c == rw);
      dmem_if.dmem_rdata_i  = (c == rw) ? rd : $urandom;
      #1;
      total++;
      if ({dmem_if.dmem_req_o, reg_we_o, csr_we_o, bus_err_o} !== 4'b0000) begin
        bad++;
        $display("FAIL rsp_wait: got req/we/csr/err=%b want 0000",
                 {dmem_if.dmem_req_o, reg_we_o, csr_we_o, bus_err_o});
      end
      if (stall_req_o === 1'b1) st++;
      @(posedge clk); #1;
    end
    dmem_if.dmem_rvalid_i = 1'b0;
    obs_stalls = st;
    total++;
    if (st != 1 + gw + rw) begin
      bad++;
      $display("FAIL stall_count op=%0d: got %0d want %0d", op, st, 1 + gw + rw);
    end
    ewb = (op <= 4'd5) ? m_load(op, addr, rd) : rwd;
    total++;
    if ({reg_we_o, reg_waddr_o, reg_wdata_o, csr_we_o} !== {rwe, wa, ewb, 1'b0}) begin
      bad++;
      $display("FAIL writeback op=%0d: got we=%b wa=%0d wd=%h csr=%b want we=%b wa=%0d wd=%h csr=0",
               op, reg_we_o, reg_waddr_o, reg_wdata_o, csr_we_o, rwe, wa, ewb);
    end
  endtask

  task automatic do_nonmem(input logic [3:0] op, input logic cwe, input logic [11:0] ca, input logic [31:0] cd);
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    wa = 5'($urandom); wd = $urandom; we = 1'($urandom);
    mem_op_i = op; mem_addr_i = $urandom; mem_data_i = $urandom; mem_we_i = 1'b0;
    reg_we_i = we; reg_waddr_i = wa; reg_wdata_i = wd;
    csr_we_i = cwe; csr_waddr_i = ca; csr_wdata_i = cd;
    dmem_if.dmem_gnt_i = 1'b1;
    #1;
    total++;
    if ({dmem_if.dmem_req_o, stall_req_o} !== 2'b00) begin
      bad++;
      $display("FAIL nonmem_req op=%0d: got req/stall=%b want 00", op, {dmem_if.dmem_req_o, stall_req_o});
    end
    @(posedge clk); #1;
    dmem_if.dmem_gnt_i = 1'b0;
    total++;
    if ({reg_we_o, reg_waddr_o, reg_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o} !== {we, wa, wd, cwe, ca, cd}) begin
      bad++;
      $display("FAIL nonmem_wb op=%0d: got %b/%0d/%h csr %b/%h/%h want %b/%0d/%h csr %b/%h/%h", op,
               reg_we_o, reg_waddr_o, reg_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o, we, wa, wd, cwe, ca, cd);
    end
  endtask

  task automatic do_misaligned(input logic [3:0] op, input logic [31:0] addr);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = $urandom; mem_we_i = (op >= 4'd6);
    reg_we_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = $urandom;
    csr_we_i = 1'b1; csr_waddr_i = 12'h123; csr_wdata_i = $urandom;
    dmem_if.dmem_gnt_i = 1'b1;
    #1;
    total++;
    if ({dmem_if.dmem_req_o, stall_req_o} !== 2'b00) begin
      bad++;
      $display("FAIL misal_req addr=%h: got req/stall=%b want 00", addr, {dmem_if.dmem_req_o, stall_req_o});
    end
    @(posedge clk); #1;
    total++;
    if ({misaligned_o, fault_addr_o, reg_we_o, csr_we_o} !== {1'b1, addr, 2'b00}) begin
      bad++;
      $display("FAIL misal_pulse: got mis=%b fa=%h we=%b csr=%b want mis=1 fa=%h we=0 csr=0",
               misaligned_o, fault_addr_o, reg_we_o, csr_we_o, addr);
    end
    idle_inputs();
    @(posedge clk); #1;
    total++;
    if (misaligned_o !== 1'b0) begin
      bad++;
      $display("FAIL misal_clear: got %b want 0", misaligned_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mem_op_i = 4'd3; mem_addr_i = 32'h40;
    dmem_if.dmem_gnt_i = 1'b1; dmem_if.dmem_rvalid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({dmem_if.dmem_req_o, stall_req_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_comb: got req/stall=%b want 00", {dmem_if.dmem_req_o, stall_req_o});
    end
    total++;
    if ({reg_waddr_o, reg_we_o, reg_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o,
         misaligned_o, fault_addr_o, bus_err_o} !== '0) begin
      bad++;
      $display("FAIL reset_regs: got we=%b wd=%h csr=%b mis=%b fa=%h err=%b want all 0",
               reg_we_o, reg_wdata_o, csr_we_o, misaligned_o, fault_addr_o, bus_err_o);
    end
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    do_mem(4'd1, 32'h1003, 32'h0, 32'h80FF_FF12, 0, 0, 1'b1);
    total++;
    if ({obs_addr, obs_be, reg_wdata_o} !== {32'h1000, 4'b1000, 32'hFFFF_FF80} || obs_stalls != 1) begin
      bad++;
      $display("FAIL lb_directed: got addr=%h be=%b wd=%h stalls=%0d want 1000/1000/ffffff80/1",
               obs_addr, obs_be, reg_wdata_o, obs_stalls);
    end
  endtask

  task automatic test_store_half();
    do_mem(4'd7, 32'h2002, 32'h1234_ABCD, $urandom, 3, 0, 1'b0);
    total++;
    if ({obs_be, obs_wdata, reg_we_o} !== {4'b1100, 32'hABCD_ABCD, 1'b0} || obs_stalls != 4) begin
      bad++;
      $display("FAIL sh_directed: got be=%b wd=%h we=%b stalls=%0d want 1100/abcdabcd/0/4",
               obs_be, obs_wdata, reg_we_o, obs_stalls);
    end
  endtask

  task automatic test_misaligned();
    do_misaligned(4'd3, 32'h3001);
    do_misaligned(4'd5, 32'h0000_0103);
    do_misaligned(4'd8, 32'hABCD_0002);
  endtask

  task automatic test_nonmem();
    do_nonmem(4'd0, 1'b1, 12'h300, 32'h8);
    do_nonmem(4'd12, 1'b0, 12'hFFF, 32'hDEAD_BEEF);
  endtask

  task automatic test_back_to_back();
    do_mem(4'd3, 32'h0000_0100, 32'h0, 32'h1122_3344, 0, 0, 1'b1);
    do_mem(4'd8, 32'h0000_0104, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);
    do_mem(4'd4, 32'h0000_0106, 32'h0, 32'h00F0_0000, 0, 1, 1'b1);
    do_mem(4'd2, 32'h0000_0102, 32'h0, 32'h8001_0000, 1, 2, 1'b1);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_rsp();
    idle_inputs();
    mem_op_i = 4'd3; mem_addr_i = 32'h50; reg_we_i = 1'b1;
    dmem_if.dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_if.dmem_gnt_i = 1'b0;
    total++;
    if ({dmem_if.dmem_req_o, stall_req_o} !== 2'b01) begin
      bad++;
      $display("FAIL rsp_state: got req/stall=%b want 01", {dmem_if.dmem_req_o, stall_req_o});
    end
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_if.dmem_rvalid_i = 1'b1; dmem_if.dmem_rdata_i = 32'h5A5A_5A5A;
    #1;
    total++;
    if ({dmem_if.dmem_req_o, stall_req_o, reg_we_o, reg_wdata_o} !== 35'd0) begin
      bad++;
      $display("FAIL rst_rsp_regs: got req=%b stall=%b we=%b wd=%h want 0/0/0/0",
               dmem_if.dmem_req_o, stall_req_o, reg_we_o, reg_wdata_o);
    end
    @(posedge clk); #1;
    dmem_if.dmem_rvalid_i = 1'b0;
    total++;
    if ({reg_we_o, reg_wdata_o, csr_we_o} !== 34'd0) begin
      bad++;
      $display("FAIL late_rvalid: got we=%b wd=%h csr=%b want 0/0/0", reg_we_o, reg_wdata_o, csr_we_o);
    end
    do_mem(4'd3, 32'h60, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b1);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    int          kind, sz;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        op = (($urandom_range(0, 1)) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        do_nonmem(op, 1'($urandom), 12'($urandom), $urandom);
      end else if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: op = 4'd2; 1: op = 4'd5; 2: op = 4'd7; 3: op = 4'd3; default: op = 4'd8;
        endcase
        a = $urandom;
        if (op_size(op) == 2) a = a | 32'h1;
        else a = (a & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        do_misaligned(op, a);
      end else begin
        op = 4'($urandom_range(1, 8));
        sz = op_size(op);
        a = $urandom & ~32'(sz - 1);
        do_mem(op, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
               (op <= 4'd5) ? 1'($urandom) : 1'b0);
      end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

`ifdef LSU_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int st;
    idle_inputs();
    mem_op_i = 4'd3; mem_addr_i = 32'h700; reg_we_i = 1'b1;
    st = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall_req_o !== 1'b1) break;
      st++;
      @(posedge clk); #1;
    end
    total++;
    if (st != TO) begin
      bad++;
      $display("FAIL timeout_stalls: got %0d want %0d", st, TO);
    end
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if ({bus_err_o, reg_we_o} !== 2'b10) begin
      bad++;
      $display("FAIL timeout_err: got err/we=%b want 10", {bus_err_o, reg_we_o});
    end
    @(posedge clk); #1;
    total++;
    if (bus_err_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %b want 0", bus_err_o);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_mem(4'd3, 32'h700, 32'h0, 32'h7777_0001, 3 * TO, TO + 2, 1'b1);
    idle_inputs();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_nonmem();
    test_back_to_back();
    test_reset_in_rsp();
`ifdef LSU_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
